// File: rtl/mem_burst_sp.sv
// Single-port burst scratchpad: one read or write burst at a time, strided addressing,
// byte-strobed writes and a two-entry skid buffer that keeps reads backpressure-safe.
module mem_burst_sp #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int LEN_W     = 12,
  parameter     INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [ADDR_W-1:0]  cmd_stride,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_strb,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_last,
  output logic               busy
);
  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  ram_q_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;

  // Skid buffer: head entry drives the read channel, tail absorbs the beat in flight.
  logic [1:0]        buf_cnt_reg;
  logic [WIDTH-1:0]  head_data_reg;
  logic              head_last_reg;
  logic [WIDTH-1:0]  tail_data_reg;
  logic              tail_last_reg;

  logic              cmd_fire;
  logic              wr_fire;
  logic              rd_pop;
  logic              rd_issue;
  logic              last_beat;
  logic [1:0]        occ_after_pop;

  assign cmd_ready = (state_reg == S_IDLE) && (buf_cnt_reg == 2'd0) && !inflight_reg;
  assign busy      = (state_reg != S_IDLE) || (buf_cnt_reg != 2'd0) || inflight_reg;
  assign wr_ready  = (state_reg == S_WRITE);
  assign rd_valid  = (buf_cnt_reg != 2'd0);
  assign rd_data   = head_data_reg;
  assign rd_last   = head_last_reg && rd_valid;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_pop    = rd_valid && rd_ready;
  assign last_beat = (cnt_reg == len_reg);

  // Count the slot freed by this cycle's pop so a continuously ready sink sees no bubbles.
  always_comb begin
    occ_after_pop = buf_cnt_reg - {1'b0, rd_pop};
    rd_issue      = 1'b0;
    if (state_reg == S_READ)
      rd_issue = (occ_after_pop == 2'd0) || ((occ_after_pop == 2'd1) && !inflight_reg);
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b])
          mem[addr_reg][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_issue)
      ram_q_reg <= mem[addr_reg];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= S_IDLE;
      addr_reg          <= '0;
      stride_reg        <= '0;
      len_reg           <= '0;
      cnt_reg           <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      buf_cnt_reg       <= 2'd0;
      head_data_reg     <= '0;
      head_last_reg     <= 1'b0;
      tail_data_reg     <= '0;
      tail_last_reg     <= 1'b0;
    end else begin
      inflight_reg      <= rd_issue;
      inflight_last_reg <= rd_issue && last_beat;

      case (state_reg)
        S_IDLE: begin
          if (cmd_fire) begin
            addr_reg   <= cmd_addr;
            stride_reg <= cmd_stride;
            len_reg    <= cmd_len;
            cnt_reg    <= '0;
            state_reg  <= cmd_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            addr_reg <= addr_reg + stride_reg;
            cnt_reg  <= cnt_reg + 1'b1;
            if (last_beat)
              state_reg <= S_IDLE;
          end
        end
        S_READ: begin
          if (rd_issue) begin
            addr_reg <= addr_reg + stride_reg;
            cnt_reg  <= cnt_reg + 1'b1;
            if (last_beat)
              state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      case ({inflight_reg, rd_pop})
        2'b10: begin
          if (buf_cnt_reg == 2'd0) begin
            head_data_reg <= ram_q_reg;
            head_last_reg <= inflight_last_reg;
          end else begin
            tail_data_reg <= ram_q_reg;
            tail_last_reg <= inflight_last_reg;
          end
          buf_cnt_reg <= buf_cnt_reg + 2'd1;
        end
        2'b01: begin
          head_data_reg <= tail_data_reg;
          head_last_reg <= tail_last_reg;
          buf_cnt_reg   <= buf_cnt_reg - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_reg == 2'd1) begin
            head_data_reg <= ram_q_reg;
            head_last_reg <= inflight_last_reg;
          end else begin
            head_data_reg <= tail_data_reg;
            head_last_reg <= tail_last_reg;
            tail_data_reg <= ram_q_reg;
            tail_last_reg <= inflight_last_reg;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_sp.sv
// Bench for mem_burst_sp: a word-array model predicts every read beat; a negedge monitor
// compares the read channel against the expected-beat queue on every valid cycle.
module tb_mem_burst_sp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr, cmd_stride;
  logic [11:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last, busy;
  logic [63:0] rd_data;

  always #5 clk = ~clk;

  mem_burst_sp #(.WIDTH(64), .DEPTH(4096), .LEN_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy)
  );

  typedef struct packed { logic [63:0] d; logic l; } beat_t;

  logic [63:0] mdl [4096];
  beat_t       exp_q[$];
  logic [63:0] got_q[$];
  logic        got_last_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  int          pat = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Read-channel monitor: head beat must match the model every valid cycle, stalled or not.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (exp_q.size() != 0)
        check("cmd_ready_while_pending", cmd_ready, 1'b0);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", rd_valid, 1'b0);
        end else begin
          check("rd_data", rd_data, exp_q[0].d);
          check("rd_last", rd_last, exp_q[0].l);
          if (rd_ready) begin
            got_q.push_back(rd_data);
            got_last_q.push_back(rd_last);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: rd_ready = 1'b1;
        1: rd_ready = ($urandom_range(0, 2) != 0);
        default: begin rd_ready = (pat % 3 == 0); pat++; end
      endcase
    end
  end

  task automatic fill_rand(input int n, input bit full);
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < n; i++) begin
      wd_q.push_back({$urandom, $urandom});
      ws_q.push_back(full ? 8'hFF : 8'($urandom));
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_cmd(input bit w, input int a, input int len, input int stride);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = w;
    cmd_addr = a[11:0]; cmd_len = len[11:0]; cmd_stride = stride[11:0];
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic write_burst(input int a, input int len, input int stride, input int abort_at);
    int addr = a;
    int fired = 0;
    send_cmd(1'b1, a, len, stride);
    for (int k = 0; k < 20000 && fired <= len; k++) begin
      if (abort_at >= 0 && fired == abort_at) break;
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = wd_q[fired];
      wr_strb  = ws_q[fired];
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        for (int b = 0; b < 8; b++)
          if (ws_q[fired][b]) mdl[addr][8*b +: 8] = wd_q[fired][8*b +: 8];
        addr = (addr + stride) % 4096;
        fired++;
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    if (abort_at >= 0) begin
      hold_reset();
    end else if (fired <= len) begin
      check("write_timeout", 1'b0, 1'b1);
    end else begin
      @(negedge clk);
      check("cmd_ready_after_write", cmd_ready, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic read_burst(input int a, input int len, input int stride, input bit timing,
                            input int abort_after);
    bit done = 1'b0;
    got_q.delete(); got_last_q.delete();
    send_cmd(1'b0, a, len, stride);
    for (int i = 0; i <= len; i++)
      exp_q.push_back('{d: mdl[(a + i * stride) % 4096], l: (i == len)});
    if (timing) begin
      @(negedge clk); check("rd_valid_accept+0", rd_valid, 1'b0);
      @(negedge clk); check("rd_valid_accept+1", rd_valid, 1'b0);
      @(negedge clk); check("rd_valid_accept+2", rd_valid, 1'b1);
      for (int i = 0; i < len; i++) begin
        @(negedge clk); check("rd_valid_no_bubble", rd_valid, 1'b1);
      end
    end
    if (abort_after > 0) begin
      for (int k = 0; k < 3000 && got_q.size() < abort_after; k++) begin
        @(negedge clk); #1;
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_read_reset_rd_valid", rd_valid, 1'b0);
      check("mid_read_reset_busy", busy, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      for (int k = 0; k < 3000 && !done; k++) begin
        @(negedge clk); #1;
        if (exp_q.size() == 0 && cmd_ready) done = 1'b1;
      end
      if (!done) check("read_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_stride = '0; wr_valid = 1'b0; wr_data = '0; wr_strb = '0;

    // Reset state
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_wr_ready", wr_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // Give every word a known value so any later read is predictable
    fill_rand(4096, 1'b1);
    write_burst(0, 4095, 1, -1);

    // Basic write then read back with latency and rd_last placement
    wd_q = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    ws_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    write_burst(16, 3, 1, -1);
    read_burst(16, 3, 1, 1'b1, 0);
    check("basic_beats", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check("basic_data", got_q[i], 64'hA0 + 64'(i));
      check("basic_last", got_last_q[i], (i == 3));
    end

    // Byte strobes, plus wr_valid while idle must not touch memory
    wd_q = '{64'h1122334455667788}; ws_q = '{8'hFF};
    write_burst(32, 0, 1, -1);
    wd_q = '{64'hFFFFFFFFFFFFFFFF}; ws_q = '{8'h0F};
    write_burst(32, 0, 1, -1);
    wr_valid = 1'b1; wr_data = 64'h0; wr_strb = 8'hFF;
    repeat (3) @(posedge clk);
    #1 wr_valid = 1'b0;
    read_burst(32, 1, 1, 1'b0, 0);
    check("strobe_word", got_q.size() > 0 ? got_q[0] : 64'hX, 64'h11223344FFFFFFFF);
    check("strobe_model", mdl[32], 64'h11223344FFFFFFFF);

    // Address wrap on write, strided read
    fill_rand(4, 1'b1);
    write_burst(4094, 3, 1, -1);
    check("wrap_model_w0", mdl[0], wd_q[2]);
    check("wrap_model_w1", mdl[1], wd_q[3]);
    read_burst(0, 7, 16, 1'b0, 0);
    check("stride_beats", got_q.size(), 8);
    check("stride_first", got_q.size() > 0 ? got_q[0] : 64'hX, wd_q[2]);

    // Backpressure pattern 1,0,0,...
    rdy_mode = 2; pat = 0;
    read_burst(200, 7, 1, 1'b0, 0);
    check("backpressure_beats", got_q.size(), 8);
    rdy_mode = 0;

    // Reset mid-read and mid-write; memory must survive
    read_burst(300, 7, 1, 1'b0, 3);
    read_burst(300, 7, 1, 1'b0, 0);
    check("reread_beats", got_q.size(), 8);
    fill_rand(8, 1'b1);
    write_burst(400, 7, 1, 3);
    read_burst(400, 7, 1, 1'b0, 0);
    check("partial_write_word0", got_q.size() > 0 ? got_q[0] : 64'hX, wd_q[0]);

    // Randomised command mix with random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int a, len, stride;
      a      = $urandom_range(0, 4095);
      len    = $urandom_range(0, 15);
      stride = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 4095);
      if ($urandom_range(0, 1) == 1) begin
        fill_rand(len + 1, 1'b0);
        write_burst(a, len, stride, -1);
      end else begin
        read_burst(a, len, stride, 1'b0, 0);
        check("rand_beats", got_q.size(), len + 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
